// File: rtl/mem_alu_seq_if.sv
// Instruction handshake between the sequencer (master) and the memory ALU (slave).
// INSTR_W is derived from ADDR_W: {op[3:0], a, b, d}.
interface mem_alu_seq_if #(
    parameter int ADDR_W = 4
);
    localparam int INSTR_W = 4 + 3 * ADDR_W;

    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic               instr_ready;

    modport master (output instr_valid, output instr, input instr_ready);
    modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/mem_alu_seq.sv
// Memory-to-memory ALU: DEPTH x DATA_W register file, one instruction per handshake,
// iterative restoring divider for DIV/MOD.
module mem_alu_seq #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    mem_alu_seq_if.slave                   bus,
    output logic                           done,
    output logic [DATA_W-1:0]              result,
    output logic                           flag_zero,
    output logic                           flag_dz,
    output logic [DATA_W*(2**ADDR_W)-1:0]  mem_flat
);
    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int INSTR_W = 4 + 3 * ADDR_W;
    localparam int IMM_W   = 2 * ADDR_W;
    localparam int CNT_W   = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DIV} state_e;
    typedef enum logic [3:0] {
        OP_LDI = 4'h0, OP_EQ = 4'h1, OP_LT = 4'h2, OP_LE = 4'h3, OP_OR = 4'h4,
        OP_AND = 4'h8, OP_XOR, OP_NOT, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD
    } op_e;

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [DATA_W-1:0]   r1_q, r1_d, r2_q, r2_d;
    logic [IMM_W-1:0]    imm_q, imm_d;
    logic [DATA_W-1:0]   rem_q, rem_d, quo_q, quo_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                done_q, done_d;
    logic                flag_zero_q, flag_zero_d;
    logic                flag_dz_q, flag_dz_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic [DATA_W+IMM_W-1:0] imm_ext;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_wr;
    logic [DATA_W:0]     trial;
    logic                qbit;
    logic [DATA_W-1:0]   rem_step, quo_step;
    logic                is_div;
    logic                ret, ret_dz, wr_en;
    logic [DATA_W-1:0]   ret_val;

    always_comb begin
        imm_ext = {{DATA_W{1'b0}}, imm_q};
        alu_res = '0;
        alu_wr  = 1'b1;
        case (op_q)
            OP_LDI:  alu_res = imm_ext[DATA_W-1:0];
            OP_EQ:   alu_res = {{(DATA_W-1){1'b0}}, r1_q == r2_q};
            OP_LT:   alu_res = {{(DATA_W-1){1'b0}}, r1_q <  r2_q};
            OP_LE:   alu_res = {{(DATA_W-1){1'b0}}, r1_q <= r2_q};
            OP_OR:   alu_res = r1_q | r2_q;
            OP_AND:  alu_res = r1_q & r2_q;
            OP_XOR:  alu_res = r1_q ^ r2_q;
            OP_NOT:  alu_res = ~r1_q;
            OP_ADD:  alu_res = r1_q + r2_q;
            OP_SUB:  alu_res = r1_q - r2_q;
            OP_MUL:  alu_res = r1_q * r2_q;
            default: begin
                alu_res = '0;
                alu_wr  = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        dst_d       = dst_q;
        r1_d        = r1_q;
        r2_d        = r2_q;
        imm_d       = imm_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        flag_zero_d = flag_zero_q;
        flag_dz_d   = flag_dz_q;
        done_d      = 1'b0;
        ret         = 1'b0;
        ret_dz      = 1'b0;
        ret_val     = '0;
        wr_en       = 1'b0;
        is_div      = (op_q == OP_DIV) || (op_q == OP_MOD);

        // Restoring step: quo_q shifts the dividend out MSB-first while quotient bits shift in.
        trial    = {rem_q, quo_q[DATA_W-1]};
        qbit     = (trial >= {1'b0, r2_q});
        rem_step = qbit ? DATA_W'(trial - {1'b0, r2_q}) : trial[DATA_W-1:0];
        quo_step = {quo_q[DATA_W-2:0], qbit};

        case (state_q)
            S_IDLE: begin
                if (bus.instr_valid) begin
                    op_d    = op_e'(bus.instr[INSTR_W-1 -: 4]);
                    r1_d    = mem_q[bus.instr[3*ADDR_W-1 -: ADDR_W]];
                    r2_d    = mem_q[bus.instr[2*ADDR_W-1 -: ADDR_W]];
                    imm_d   = bus.instr[3*ADDR_W-1 : ADDR_W];
                    dst_d   = bus.instr[ADDR_W-1:0];
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_div) begin
                    if (r2_q == '0) begin
                        ret     = 1'b1;
                        ret_dz  = 1'b1;
                        wr_en   = 1'b1;
                        ret_val = (op_q == OP_DIV) ? '1 : r1_q;
                    end else begin
                        rem_d   = '0;
                        quo_d   = r1_q;
                        cnt_d   = '0;
                        state_d = S_DIV;
                    end
                end else begin
                    ret     = 1'b1;
                    wr_en   = alu_wr;
                    ret_val = alu_res;
                end
            end
            S_DIV: begin
                rem_d = rem_step;
                quo_d = quo_step;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    ret     = 1'b1;
                    wr_en   = 1'b1;
                    ret_val = (op_q == OP_DIV) ? quo_step : rem_step;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (ret) begin
            done_d      = 1'b1;
            result_d    = ret_val;
            flag_zero_d = (ret_val == '0);
            flag_dz_d   = ret_dz;
            state_d     = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_LDI;
            dst_q       <= '0;
            r1_q        <= '0;
            r2_q        <= '0;
            imm_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            done_q      <= 1'b0;
            flag_zero_q <= 1'b0;
            flag_dz_q   <= 1'b0;
            for (int unsigned k = 0; k < DEPTH; k++) mem_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            dst_q       <= dst_d;
            r1_q        <= r1_d;
            r2_q        <= r2_d;
            imm_q       <= imm_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            done_q      <= done_d;
            flag_zero_q <= flag_zero_d;
            flag_dz_q   <= flag_dz_d;
            if (wr_en) mem_q[dst_q] <= ret_val;
        end
    end

    always_comb begin
        bus.instr_ready = (state_q == S_IDLE);
        done            = done_q;
        result          = result_q;
        flag_zero       = flag_zero_q;
        flag_dz         = flag_dz_q;
        for (int unsigned k = 0; k < DEPTH; k++) mem_flat[k*DATA_W +: DATA_W] = mem_q[k];
    end
endmodule

// File: tb/tb_mem_alu_seq.sv
// Bench for mem_alu_seq: directed scenarios plus random instructions against
// an arithmetic reference model of the register file.
module tb_mem_alu_seq;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int NW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_alu_seq_if #(.ADDR_W(AW)) bus ();
    logic              done;
    logic [DW-1:0]     result;
    logic              flag_zero;
    logic              flag_dz;
    logic [DW*NW-1:0]  mem_flat;

    mem_alu_seq #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .done      (done),
        .result    (result),
        .flag_zero (flag_zero),
        .flag_dz   (flag_dz),
        .mem_flat  (mem_flat)
    );

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int unsigned last_wait = 0;
    logic [7:0]  mem_m [NW];
    logic [7:0]  res_m;
    bit          fz_m, fdz_m;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] flat_m();
        logic [127:0] f;
        for (int k = 0; k < NW; k++) f[k*8 +: 8] = mem_m[k];
        return f;
    endfunction

    task automatic model(input logic [15:0] ins, output int unsigned lat);
        int unsigned op, a, b, d, r1, r2, v;
        bit wr, dz;
        op = ins[15:12]; a = ins[11:8]; b = ins[7:4]; d = ins[3:0];
        r1 = mem_m[a]; r2 = mem_m[b];
        wr = 1; dz = 0; lat = 1; v = 0;
        case (op)
            0:  v = ins[11:4];
            1:  v = (r1 == r2) ? 1 : 0;
            2:  v = (r1 <  r2) ? 1 : 0;
            3:  v = (r1 <= r2) ? 1 : 0;
            4:  v = r1 | r2;
            8:  v = r1 & r2;
            9:  v = r1 ^ r2;
            10: v = 255 - r1;
            11: v = (r1 + r2) % 256;
            12: v = (r1 + 256 - r2) % 256;
            13: v = (r1 * r2) % 256;
            14: if (r2 == 0) begin v = 255; dz = 1; end else begin v = r1 / r2; lat = DW + 1; end
            15: if (r2 == 0) begin v = r1;  dz = 1; end else begin v = r1 % r2; lat = DW + 1; end
            default: begin v = 0; wr = 0; end
        endcase
        if (wr) mem_m[d] = 8'(v);
        res_m = 8'(v);
        fz_m  = (v == 0);
        fdz_m = dz;
    endtask

    task automatic exec(input logic [15:0] ins, input bit hold);
        int unsigned waits, edges, lat, rdy_bad;
        bit seen;
        waits = 0;
        @(negedge clk);
        while (bus.instr_ready !== 1'b1 && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        last_wait = waits;
        chk("ready_wait", bus.instr_ready, 1);
        if (bus.instr_ready !== 1'b1) return;
        bus.instr = ins;
        bus.instr_valid = 1'b1;
        model(ins, lat);
        @(posedge clk);
        @(negedge clk);
        if (!hold) bus.instr_valid = 1'b0;
        chk("ready_drop", bus.instr_ready, 0);
        chk("done_pulse", done, 0);
        edges = 0; seen = 0; rdy_bad = 0;
        while (!seen && edges < 40) begin
            @(posedge clk);
            edges++;
            #1;
            if (done === 1'b1) seen = 1;
            else if (bus.instr_ready !== 1'b0) rdy_bad++;
        end
        chk("latency", edges, lat);
        chk("ready_busy", rdy_bad, 0);
        chk("ready_rise", bus.instr_ready, 1);
        chk("result", result, res_m);
        chk("flag_zero", flag_zero, fz_m);
        chk("flag_dz", flag_dz, fdz_m);
        chk("mem_flat", mem_flat, flat_m());
    endtask

    task automatic check_reset_state();
        chk("rst_ready", bus.instr_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_fz", flag_zero, 0);
        chk("rst_fdz", flag_dz, 0);
        chk("rst_mem", mem_flat, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned dbad;
        bit h;
        logic [15:0] ins;
        for (int k = 0; k < NW; k++) mem_m[k] = '0;
        res_m = '0; fz_m = 0; fdz_m = 0;
        rst = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_state();

        exec(16'h0253, 0);
        exec(16'hB334, 0);
        exec(16'h0645, 0);
        exec(16'h0076, 0);
        exec(16'hE567, 0);
        exec(16'hF568, 0);
        exec(16'hE59A, 0);
        exec(16'hC33B, 0);
        exec(16'hD44C, 0);
        exec(16'h5000, 0);

        exec(16'h0FF1, 1);
        exec(16'h1111, 0);
        chk("b2b_accept", last_wait, 0);

        // Abort a divide on its 4th iteration cycle
        exec(16'h0337, 0);
        @(negedge clk);
        bus.instr = 16'hE567;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        dbad = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0) dbad++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        if (done !== 1'b0) dbad++;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_no_done", dbad, 0);
        for (int k = 0; k < NW; k++) mem_m[k] = '0;
        res_m = '0; fz_m = 0; fdz_m = 0;
        check_reset_state();
        @(posedge clk);
        #1;
        chk("post_rst_done", done, 0);
        chk("post_rst_mem", mem_flat, 0);

        for (int i = 0; i < 300; i++) begin
            ins = 16'($urandom);
            if ($urandom_range(0, 3) == 0) ins[15:12] = 4'($urandom_range(14, 15));
            h = ($urandom_range(0, 1) == 1) && (i != 299);
            exec(ins, h);
            if (!h) begin
                bus.instr_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        bus.instr_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_alu_seq.md
# mem_alu_seq

Parametrised, handshaked successor to the team's 16-byte memory-to-memory ALU. It holds a register-file memory of DEPTH words of DATA_W bits and accepts one instruction per valid/ready handshake. Each instruction reads two operand words, computes, and writes one result word. Division and modulo use an iterative restoring divider rather than a combinational one. It sits between the instruction sequencer and the debug/observation logic, which reads the whole memory through a flat output bus.

## Interface
- DATA_W, 8, word width in bits (≥2)
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words
- INSTR_W, 4+3*ADDR_W (derived, not overridable), instruction width

- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous and active-high
- instr_valid  in  1  instruction present
- instr  in  INSTR_W  {op[3:0], a[ADDR_W-1:0], b[ADDR_W-1:0], d[ADDR_W-1:0]}, op in MSBs
- instr_ready  out  1  high only in IDLE
- done  out  1  one-cycle pulse when an instruction retires
- result  out  DATA_W  value retired (written or would-be written)
- flag_zero  out  1  result == 0 at last retire
- flag_dz  out  1  last retired DIV/MOD had divisor 0
- mem_flat  out  DATA_W*DEPTH  word k at [k*DATA_W +: DATA_W]

## Operation
- Opcodes (all unsigned) and their results:
  - 0 LDI: writes {a,b} (2*ADDR_W bits) to mem[d]; zero-extended or truncated to DATA_W.
  - 1 EQ, 2 LT, 3 LE: compare r1 against r2; result 1 or 0, zero-extended.
  - 4 OR, 8 AND, 9 XOR: bitwise on r1, r2.
  - A NOT: ~r1; b is ignored.
  - B ADD, C SUB, D MUL: keep the low DATA_W bits (wrap-around, no carry out).
  - E DIV: quotient; F MOD: remainder.
  - 5, 6, 7: NOP. No memory write; done still pulses; result = 0.
- r1 = mem[a] and r2 = mem[b] are latched at the accept edge.
- FSM states IDLE, EXEC, DIV:
  - IDLE: instr_ready = 1. On instr_valid & instr_ready, latch op, d, r1, r2; go to EXEC.
  - EXEC, non-divide op: compute, write mem[d], load result and flags, pulse done; go to IDLE.
  - EXEC, DIV/MOD with r2 == 0: write all-ones (DIV) or r1 (MOD); flag_dz = 1; pulse done; go to IDLE.
  - EXEC, DIV/MOD with r2 ≠ 0: init divider; go to DIV.
  - DIV: one quotient bit per cycle for DATA_W cycles, restoring algorithm. After the last bit: write, pulse done, flag_dz = 0; go to IDLE.
- flag_zero and flag_dz update only on done and hold otherwise. flag_dz is cleared by any non-DIV/MOD retire.
- The memory write and the done pulse take effect at the same edge.
- d may equal a or b: operands are already latched, so the old values are used.

## Timing
- Reset: memory all 0, state IDLE, result 0, done 0, flag_zero 0, flag_dz 0. instr_ready = 1 in the cycle after reset deasserts.
- Latency counts rising edges from the accept edge to the edge that asserts done:
  - Non-divide ops and divide-by-zero: 1 edge.
  - DIV/MOD with nonzero divisor: DATA_W+1 edges.
- instr_ready drops after the accept edge and rises together with done. An instruction may be accepted in the done cycle (back-to-back).
- Throughput: one instruction per 2 cycles for non-divide ops.
- instr_valid while not ready is ignored. The instruction is not captured, and the source must hold it.
- mem_flat reflects a write in the cycle after the write edge.
- rst wins over everything:
  - Mid-DIV reset aborts the instruction: no write, no done.
  - Memory is cleared.

## Test plan
(DATA_W=8, ADDR_W=4, INSTR_W=16)
- Reset, then LDI 0x0253 → mem[3] = 0x25, done 1 edge after accept, flag_zero = 0. Then ADD 0xB334 → mem[4] = 0x4A.
- LDI 0x0645 (mem[5] = 100), LDI 0x0076 (mem[6] = 7):
  - DIV 0xE567 → mem[7] = 0x0E, done exactly 9 edges after accept, instr_ready low throughout.
  - MOD 0xF568 → mem[8] = 0x02.
- mem[9] = 0 (reset value); DIV 0xE59A → mem[10] = 0xFF, flag_dz = 1, 1-edge latency. A following SUB 0xC33B → mem[11] = 0x00, flag_zero = 1, flag_dz = 0.
- Wrap-around: with mem[4] = 0x4A, MUL 0xD44C → mem[12] = 0x64 (0x4A*0x4A = 0x1564, low byte). NOP 0x5000 → done pulses, memory unchanged, result = 0.
- Back-to-back: hold instr_valid with 0x0FF1 then 0x1111 → both accepted on consecutive ready cycles; mem[1] = 0xFF, then mem[1] = 0x01.
- Reset asserted on 4th DIV cycle of 0xE567 with mem[7] preloaded 0x33 → no done, all memory 0 after reset.
